// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver with 3-sample majority or centre
// sampling, optional even/odd parity and one or two stop bits.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int VOTE       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_en,
    input  logic                 abort,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 first_tick,
    output logic                 center_tick
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int C  = OVERSAMPLE / 2;
    localparam logic [PW-1:0] P_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] P_A    = PW'(C - 1);
    localparam logic [PW-1:0] P_B    = PW'(C);
    localparam logic [PW-1:0] P_DEC  = PW'(VOTE != 0 ? C + 1 : C);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state, state_n;
    logic                   rx_m, rx_s;
    logic [PW-1:0]          phase;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   stop_idx, stop_bad, par_bit, s_a, s_b;
    logic                   tick, wrap, decide, bit_val, last_stop, perr;

    assign tick        = baud_en && !abort;
    assign wrap        = phase == P_LAST;
    assign decide      = phase == P_DEC;
    assign bit_val     = VOTE != 0 ? (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s) : rx_s;
    assign last_stop   = stop_idx == S_LAST;
    assign perr        = (PARITY != 0) && ((^shreg ^ par_bit) != (PARITY == 2));
    assign busy        = state != S_IDLE;
    // Combinational so the final stop bit's centre pulse still falls inside busy.
    assign center_tick = busy && tick && decide;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_comb begin
        state_n = state;
        if (abort)
            state_n = S_IDLE;
        else if (baud_en)
            case (state)
                S_IDLE:   if (!rx_s) state_n = S_START;
                S_START:  state_n = (decide && bit_val) ? S_IDLE : wrap ? S_DATA : S_START;
                S_DATA:   if (wrap && bit_cnt == B_LAST) state_n = PARITY != 0 ? S_PARITY : S_STOP;
                S_PARITY: if (wrap) state_n = S_STOP;
                S_STOP:   if (decide && last_stop) state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            stop_idx    <= 1'b0;
            stop_bad    <= 1'b0;
            par_bit     <= 1'b0;
            s_a         <= 1'b1;
            s_b         <= 1'b1;
            data        <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            first_tick  <= 1'b0;
        end else begin
            state      <= state_n;
            data_valid <= 1'b0;
            first_tick <= 1'b0;
            // The start-detect tick in IDLE is phase 0 of the start bit.
            if (abort || baud_en)
                phase <= (state_n == S_IDLE) ? '0 : (state == S_IDLE || !wrap) ? phase + P_ONE : '0;
            if (tick) begin
                first_tick <= (state == S_IDLE) ? !rx_s : phase == '0;
                if (phase == P_A) s_a <= rx_s;
                if (phase == P_B) s_b <= rx_s;
                if (state == S_IDLE) begin
                    bit_cnt  <= '0;
                    stop_idx <= 1'b0;
                    stop_bad <= 1'b0;
                end
                if (state == S_DATA && decide) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                if (state == S_DATA && wrap) bit_cnt <= bit_cnt + B_ONE;
                if (state == S_PARITY && decide) par_bit <= bit_val;
                if (state == S_STOP && wrap) stop_idx <= 1'b1;
                if (state == S_STOP && decide) begin
                    if (last_stop) begin
                        data       <= shreg;
                        parity_err <= perr;
                        frame_err  <= stop_bad | !bit_val;
                        data_valid <= 1'b1;
                    end else begin
                        stop_bad <= !bit_val;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed vectors for three receiver configurations
// (default, even parity, centre sampling) plus multi-cycle corner sequences.
module tb_uart_rx_sampler;
    logic clk = 1'b0;
    logic rst, baud_en, abort, rx, rx_p;
    logic [7:0] d0, d1, d2;
    logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2;
    logic b0, b1, b2, ft0, ft1, ft2, ct0, ct1, ct2;
    int tests = 0, fails = 0;
    int dv0 = 0, dv1 = 0, dv2 = 0, ticks = 0, t_start = 0, t_dv = 0;
    logic b0_q = 1'b0;

    typedef struct {
        bit         p;
        logic [7:0] w;
        logic       pb;
        logic       sb;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    uart_rx_sampler u0 (.clk(clk), .rst(rst), .baud_en(baud_en), .abort(abort), .rx(rx),
        .data(d0), .data_valid(v0), .parity_err(pe0), .frame_err(fe0), .busy(b0),
        .first_tick(ft0), .center_tick(ct0));
    uart_rx_sampler #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .baud_en(baud_en), .abort(abort), .rx(rx_p),
        .data(d1), .data_valid(v1), .parity_err(pe1), .frame_err(fe1), .busy(b1),
        .first_tick(ft1), .center_tick(ct1));
    uart_rx_sampler #(.VOTE(0)) u2 (.clk(clk), .rst(rst), .baud_en(baud_en), .abort(abort), .rx(rx),
        .data(d2), .data_valid(v2), .parity_err(pe2), .frame_err(fe2), .busy(b2),
        .first_tick(ft2), .center_tick(ct2));

    initial begin
        baud_en = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_en = 1'b1;
            @(negedge clk);
            baud_en = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (baud_en) ticks <= ticks + 1;
        dv0 <= dv0 + int'(v0);
        dv1 <= dv1 + int'(v1);
        dv2 <= dv2 + int'(v2);
    end

    always @(negedge clk) begin
        b0_q <= b0;
        if (b0 && !b0_q) t_start <= ticks;
        if (v0) t_dv <= ticks;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (!baud_en) @(posedge clk);
        #1;
    endtask

    task automatic ticks_n(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic set_line(input bit p, input logic b);
        if (p) rx_p = b;
        else rx = b;
    endtask

    task automatic send_bit(input bit p, input logic b);
        set_line(p, b);
        ticks_n(16);
    endtask

    // g selects a data bit that gets a one-tick inversion at phase 8.
    task automatic send_frame(input bit p, input logic [7:0] w, input logic pb, input logic sb,
                              input int g, input logic idle);
        send_bit(p, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == g) begin
                set_line(p, w[i]);
                ticks_n(8);
                set_line(p, !w[i]);
                ticks_n(1);
                set_line(p, w[i]);
                ticks_n(7);
            end else begin
                send_bit(p, w[i]);
            end
        end
        if (p) send_bit(p, pb);
        send_bit(p, sb);
        set_line(p, idle);
    endtask

    initial begin
        int n0, n1, n2;
        vecs[0] = '{1'b0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

        rst = 1'b1; abort = 1'b0; rx = 1'b1; rx_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", d0, 0);
        check("reset_flags", {v0, pe0, fe0, b0, ft0, ct0}, 0);
        rst = 1'b0;
        ticks_n(10);
        check("idle_busy", b0, 0);

        n0 = dv0; n2 = dv2;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1, 1'b1);
        ticks_n(8);
        check("a5_data", d0, 8'hA5);
        check("a5_flags", {pe0, fe0}, 0);
        check("a5_valid_count", dv0 - n0, 1);
        check("a5_latency", t_dv - t_start, 153);
        check("a5_data_vote0", d2, 8'hA5);
        check("a5_valid_vote0", dv2 - n2, 1);

        n0 = dv0; n2 = dv2;
        rx = 1'b0;
        wait_tick();
        check("fs_busy_rise", b0, 1);
        check("fs_first_tick", ft0, 1);
        ticks_n(4);
        rx = 1'b1;
        ticks_n(3);
        check("fs_busy_ph7", {b0, b2}, 2'b11);
        ticks_n(1);
        check("fs_busy_ph8", {b0, b2}, 2'b10);
        @(negedge clk);
        while (!baud_en) @(negedge clk);
        #1;
        check("fs_center_tick", ct0, 1);
        wait_tick();
        check("fs_busy_ph9", b0, 0);
        check("fs_no_valid", (dv0 - n0) + (dv2 - n2), 0);
        ticks_n(4);

        foreach (vecs[i]) begin
            n0 = dv0; n1 = dv1; n2 = dv2;
            send_frame(vecs[i].p, vecs[i].w, vecs[i].pb, vecs[i].sb, -1, 1'b1);
            ticks_n(24);
            if (vecs[i].p) begin
                check($sformatf("vec%0d_data", i), d1, vecs[i].ed);
                check($sformatf("vec%0d_flags", i), {pe1, fe1}, {vecs[i].epe, vecs[i].efe});
                check($sformatf("vec%0d_count", i), dv1 - n1, 1);
            end else begin
                check($sformatf("vec%0d_data", i), d0, vecs[i].ed);
                check($sformatf("vec%0d_flags", i), {pe0, fe0}, {vecs[i].epe, vecs[i].efe});
                check($sformatf("vec%0d_count", i), dv0 - n0, 1);
                check($sformatf("vec%0d_data_vote0", i), d2, vecs[i].ed);
            end
        end

        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 3, 1'b1);
        ticks_n(8);
        check("glitch_vote1", d0, 8'hA5);
        check("glitch_vote0", d2, 8'hAD);

        n0 = dv0;
        set_line(1'b0, 1'b0);
        ticks_n(16);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'(8'hC3 >> i));
        set_line(1'b0, 1'b0);
        ticks_n(3);
        rst = 1'b1;
        #1;
        check("rst_mid_data", {d0, d1, d2}, 0);
        check("rst_mid_flags", {v0, pe0, fe0, b0, ft0, ct0, b1, b2}, 0);
        repeat (4) @(posedge clk);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        ticks_n(20);
        check("rst_resume_idle", b0, 0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, -1, 1'b1);
        ticks_n(8);
        check("rst_3c_data", d0, 8'h3C);
        check("rst_3c_count", dv0 - n0, 1);

        n0 = dv0;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, -1, 1'b0);
        check("brk_first_data", d0, 8'h55);
        check("brk_first_ferr", fe0, 1);
        ticks_n(160);
        check("brk_second_data", d0, 8'h00);
        check("brk_second_ferr", fe0, 1);
        check("brk_count", dv0 - n0, 2);
        check("brk_busy", b0, 1);
        rx = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", b0, 0);
        check("abort_hold_data", {d0, fe0}, {8'h00, 1'b1});
        ticks_n(24);
        check("abort_count", dv0 - n0, 2);
        check("abort_idle", b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
